// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: D = A - B - Bin, one SLICE-bit chunk per clock, LSB slice first.
// Start/busy/done handshake; results and flags update only on the edge entering DONE.
module serial_subtractor #(
   parameter int WIDTH = 64,
   parameter int SLICE = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             bin_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] d_o,
   output logic             bout_o,
   output logic             zero_o,
   output logic             ovf_o
);
   // state | meaning
   // IDLE  | waiting for start; results hold last completion
   // RUN   | one slice subtracted per cycle
   // DONE  | single-cycle completion pulse

   localparam int NSLICE = WIDTH / SLICE;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               borrow_q, borrow_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d;
   logic [WIDTH-1:0]   d_q, d_d;
   logic               bout_q, bout_d, zero_q, zero_d, ovf_q, ovf_d;

   logic [SLICE-1:0]   a_sl, b_sl;
   logic [SLICE:0]     sub;

   // Operand slice selected by a compare per slice so all part-selects stay constant.
   always_comb begin
      a_sl = '0;
      b_sl = '0;
      for (int k = 0; k < NSLICE; k++) begin
         if (cnt_q == CW'(k)) begin
            a_sl = a_q[k*SLICE +: SLICE];
            b_sl = b_q[k*SLICE +: SLICE];
         end
      end
      sub = {1'b0, a_sl} - {1'b0, b_sl} - {{SLICE{1'b0}}, borrow_q};
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      borrow_d = borrow_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      d_d      = d_q;
      bout_d   = bout_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               a_d      = a_i;
               b_d      = b_i;
               borrow_d = bin_i;
               cnt_d    = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            for (int k = 0; k < NSLICE; k++) begin
               if (cnt_q == CW'(k)) acc_d[k*SLICE +: SLICE] = sub[SLICE-1:0];
            end
            borrow_d = sub[SLICE];
            if (cnt_q == CW'(NSLICE-1)) begin
               d_d     = acc_d;
               bout_d  = sub[SLICE];
               zero_d  = (acc_d == '0);
               ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (acc_d[WIDTH-1] != a_q[WIDTH-1]);
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         borrow_q <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         d_q      <= '0;
         bout_q   <= 1'b0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         borrow_q <= borrow_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         d_q      <= d_d;
         bout_q   <= bout_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy_o = (state_q == RUN);
   assign done_o = (state_q == DONE);
   assign d_o    = d_q;
   assign bout_o = bout_q;
   assign zero_o = zero_q;
   assign ovf_o  = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: hand-computed vectors, handshake, back-to-back and abort.
module tb_serial_subtractor;
   logic        clk = 1'b0;
   logic        rst, start, bin;
   logic [63:0] a, b;
   logic        busy, done, bout, zero, ovf;
   logic [63:0] d;
   int          checks   = 0;
   int          failures = 0;

   serial_subtractor #(.WIDTH(64), .SLICE(8)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .a_i(a), .b_i(b), .bin_i(bin),
      .busy_o(busy), .done_o(done), .d_o(d), .bout_o(bout), .zero_o(zero), .ovf_o(ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [63:0] ed, input logic eb,
                             input logic ez, input logic eo);
      check({tag, "_d"},    d,    ed);
      check({tag, "_bout"}, 64'(bout), 64'(eb));
      check({tag, "_zero"}, 64'(zero), 64'(ez));
      check({tag, "_ovf"},  64'(ovf),  64'(eo));
   endtask

   // Launch one operation, scramble the inputs after acceptance, then check latency and results.
   task automatic run_op(input string tag, input logic [63:0] av, input logic [63:0] bv,
                         input logic bi, input logic [63:0] ed, input logic eb,
                         input logic ez, input logic eo);
      int cyc = 0;
      int nbusy = 0;
      bit seen = 0;
      @(negedge clk);
      a = av; b = bv; bin = bi; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a = ~av; b = ~bv; bin = ~bi;
      while (!seen && cyc < 20) begin
         if (busy) nbusy++;
         if (done) seen = 1;
         else begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      check({tag, "_seen"},  64'(seen),  64'd1);
      check({tag, "_lat"},   64'(cyc),   64'd8);
      check({tag, "_busy"},  64'(nbusy), 64'd8);
      check_outs(tag, ed, eb, ez, eo);
      @(posedge clk); #1;
      check({tag, "_pulse"}, 64'(done), 64'd0);
      check({tag, "_hold"},  d,         ed);
   endtask

   initial begin
      int cyc, c1, c2, ndone;
      bit seen;
      rst = 1'b1; start = 1'b1; a = 64'hDEAD; b = 64'h1; bin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check_outs("rst", 64'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0; start = 1'b0;

      run_op("basic",  64'h10, 64'h01, 1'b0, 64'h000000000000000F, 1'b0, 1'b0, 1'b0);
      run_op("ripple", 64'h0,  64'h1,  1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0, 1'b0);
      run_op("binrip", 64'h7F, 64'h7F, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0, 1'b0);
      run_op("ovf",    64'h8000000000000000, 64'h1, 1'b0, 64'h7FFFFFFFFFFFFFFF, 1'b0, 1'b0, 1'b1);
      run_op("zero",   64'h123456789ABCDEF0, 64'h123456789ABCDEF0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
      run_op("negovf", 64'h1, 64'h8000000000000000, 1'b0, 64'h8000000000000001, 1'b1, 1'b0, 1'b1);

      // Second start at E3 must be ignored.
      @(negedge clk);
      a = 64'd100; b = 64'd58; bin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a = 64'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      a = 64'd999; b = 64'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 3; seen = 0;
      while (!seen && cyc < 20) begin
         if (done) seen = 1;
         else begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      check("hs_lat", 64'(cyc), 64'd8);
      check("hs_d",   d,        64'd42);
      @(posedge clk); #1;
      check("hs_idle", 64'(busy), 64'd0);

      // start held high: two operations, second uses operands present at its acceptance.
      @(negedge clk);
      a = 64'd50; b = 64'd8; bin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      a = 64'd20; b = 64'd5;
      cyc = 0; c1 = -1; c2 = -1;
      while (c2 < 0 && cyc < 40) begin
         if (done) begin
            if (c1 < 0) begin
               c1 = cyc;
               check("held1_d", d, 64'd42);
            end else begin
               c2 = cyc;
               check("held2_d", d, 64'd15);
               start = 1'b0;
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      check("held1_lat", 64'(c1),      64'd8);
      check("held_gap",  64'(c2 - c1), 64'd10);

      // Abort during RUN; preceding results are nonzero so the clear is observable.
      run_op("pre", 64'h1, 64'h8000000000000000, 1'b0, 64'h8000000000000001, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      a = 64'd7; b = 64'd1; bin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check_outs("abort", 64'd0, 1'b0, 1'b0, 1'b0);
      ndone = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      check("abort_nodone", 64'(ndone), 64'd0);
      run_op("after", 64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
